configurable_fifo: RTL and testbench
====================================

# configurable_fifo

Parametrised synchronous FIFO that generalises the team's fixed standard/FWFT FIFO pair into one block. Read-port mode (standard registered-output or first-word-fall-through) is a parameter, and the block adds an occupancy count, programmable almost-full/almost-empty flags, and one-cycle overflow/underflow error pulses. It sits between the UART receiver/transmitter cores and the bus-side register interface, buffering characters in either direction.

## Interface
Parameters:
- `ADDR_WIDTH`, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH, all entries usable
- `DATA_WIDTH`, 8, word width in bits
- `FWFT`, 0, read mode: 0 = standard (registered `r_data`), 1 = first-word-fall-through
- `AF_LEVEL`, DEPTH-1, `almost_full` asserts when count >= `AF_LEVEL`; legal range 1..DEPTH
- `AE_LEVEL`, 1, `almost_empty` asserts when count <= `AE_LEVEL`; legal range 0..DEPTH-1

Ports:
- `clk` in 1: single clock, all state updates on rising edge
- `reset` in 1: asynchronous, active-low reset
- `rd` in 1: read request
- `wr` in 1: write request
- `w_data` in DATA_WIDTH: write data
- `r_data` out DATA_WIDTH: read data (timing depends on `FWFT`)
- `empty` out 1: count == 0
- `full` out 1: count == DEPTH
- `almost_empty` out 1: count <= `AE_LEVEL`
- `almost_full` out 1: count >= `AF_LEVEL`
- `count` out ADDR_WIDTH+1: current occupancy, 0..DEPTH
- `overflow` out 1: one-cycle pulse, write rejected
- `underflow` out 1: one-cycle pulse, read rejected

## Operation
- State: write pointer, read pointer (ADDR_WIDTH bits each, natural wrap from DEPTH-1 to 0), and `count` (ADDR_WIDTH+1 bits). Flags decode from `count` only; no extra pointer bit.
- Accepted write `wa = wr & (~full | rd)`: mem[wptr] <= w_data, wptr+1.
- Accepted read `ra = rd & ~empty`: rptr+1.
- count: +1 on wa&~ra, −1 on ra&~wa, unchanged otherwise.
- Empty with rd&wr: write accepted, read rejected, `underflow` pulses, count 0→1.
- Full with rd&wr: both accepted, count stays DEPTH, no `overflow`.
- `overflow` <= wr & full & ~rd. `underflow` <= rd & empty. Both registered, one cycle wide.
- Standard mode: `r_data` register loads mem[rptr] on `ra`, holds otherwise.
- FWFT mode: `r_data` = mem[rptr] combinationally. It is valid whenever ~empty, and `rd` acknowledges the presented word. Value while empty is don't-care.
- Reset (reset=0, any time, including mid-transfer): pointers, count, `overflow`, `underflow` and the standard-mode `r_data` register clear to 0 immediately. Memory contents are not cleared. After reset: `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0 (given legal parameters).

## Timing
- Write at edge N is visible in `count`/flags after edge N. In FWFT mode, `r_data` shows the word after edge N when the FIFO was empty.
- Standard mode read latency 1: `rd` high with ~empty in cycle N makes the word appear on `r_data` after edge N.
- FWFT read latency 0: the head word is already on `r_data`, and `rd` advances to the next word after the edge.
- Error pulses are high exactly the cycle after the offending request.
- No combinational path from `rd`/`wr` to any output.

## Structure
- Package `fifo_pkg`: `fifo_mode_e` (STANDARD, FWFT) and a `fifo_depth(addr_width)` helper function. `FWFT` is compared against the enum.
- Sub-module `fifo_ctrl` holds the pointers, count, flags and error pulses. The top holds the memory array (write-synchronous, read-asynchronous) and the mode-dependent `r_data` path, selected by generate on `FWFT`.
- Parameter legality is checked with elaboration-time assertions on `AF_LEVEL`/`AE_LEVEL`.

## Test plan
- Reset mid-stream: write 3 words, assert reset low for 1 cycle → count=0, empty=1, r_data=0 (standard), overflow=underflow=0.
- Standard mode fill/drain (ADDR_WIDTH=3): write 0x01..0x08 → full=1 and almost_full=1 at count=8. Then 8 reads → r_data 0x01..0x08, each one cycle after `rd`, empty=1 at the end.
- FWFT mode: write 0xA5 into empty FIFO → r_data=0xA5 the next cycle with no `rd`. Then `rd` → empty=1.
- Overflow/underflow: 9th write while full → overflow pulses 1 cycle, count stays 8, data intact. `rd` while empty → underflow pulses 1 cycle.
- Simultaneous rd&wr: at full, write 0x55 → count stays 8 and 0x55 is read last. At empty, write 0x33 → count=1, underflow pulses, next read returns 0x33.
- Wrap-around and thresholds (AF_LEVEL=6, AE_LEVEL=2): 20 interleaved write/read cycles crossing pointer wrap → data order preserved. almost_full toggles at count 6, almost_empty at count 2.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the configurable FIFO.
//   fifo_mode_e : read-port mode (STANDARD registered r_data, FWFT fall-through)
//   fifo_depth  : number of entries for a given pointer width
package fifo_pkg;

  typedef enum logic {
    STANDARD = 1'b0,
    FWFT     = 1'b1
  } fifo_mode_e;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// Pointer/occupancy controller for configurable_fifo.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   rd, wr            : read / write requests
//   wptr, rptr        : memory write / read addresses
//   wa, ra            : write / read accepted this cycle
//   count             : occupancy 0..DEPTH
//   empty, full       : count == 0 / count == DEPTH
//   almost_empty/full : count <= AE_LEVEL / count >= AF_LEVEL
//   overflow          : one-cycle pulse after a rejected write
//   underflow         : one-cycle pulse after a rejected read
//
// Request semantics: rd and wr are plain requests with no ready return.
// A write is taken when the FIFO has room or a read frees a slot in the
// same cycle; a read is taken whenever the FIFO is not empty. Rejected
// requests are reported one cycle later on overflow/underflow.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = fifo_depth(ADDR_WIDTH) - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd,
  input  logic                  wr,
  output logic [ADDR_WIDTH-1:0] wptr,
  output logic [ADDR_WIDTH-1:0] rptr,
  output logic                  wa,
  output logic                  ra,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);

  // Flags decode from the count register only, so no output depends
  // combinationally on rd/wr.
  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_empty = (count <= AE_C);
  assign almost_full  = (count >= AF_C);

  // A read while full frees the slot the write lands in.
  assign wa = wr & (~full | rd);
  assign ra = rd & ~empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wa) wptr <= wptr + ADDR_WIDTH'(1);
      if (ra) rptr <= rptr + ADDR_WIDTH'(1);
      if (wa && !ra)      count <= count + (ADDR_WIDTH+1)'(1);
      else if (ra && !wa) count <= count - (ADDR_WIDTH+1)'(1);
      overflow  <= wr & full & ~rd;
      underflow <= rd & empty;
    end
  end

endmodule

// File: rtl/configurable_fifo.sv
// Parametrised synchronous FIFO with selectable read mode.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   rd, wr, w_data    : read request, write request, write data
//   r_data            : read data (registered in STANDARD, fall-through in FWFT)
//   empty, full       : occupancy flags
//   almost_empty/full : programmable threshold flags
//   count             : occupancy 0..DEPTH
//   overflow/underflow: one-cycle error pulses for rejected requests
module configurable_fifo
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = fifo_depth(ADDR_WIDTH) - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam fifo_mode_e MODE = (FWFT != 0) ? fifo_pkg::FWFT : fifo_pkg::STANDARD;

  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("configurable_fifo: AF_LEVEL must be within 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("configurable_fifo: AE_LEVEL must be within 0..DEPTH-1");
  end

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic                  wa;
  logic                  ra;

  fifo_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .AF_LEVEL   (AF_LEVEL),
    .AE_LEVEL   (AE_LEVEL)
  ) u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .rd           (rd),
    .wr           (wr),
    .wptr         (wptr),
    .rptr         (rptr),
    .wa           (wa),
    .ra           (ra),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Storage is deliberately not reset; stale words are never exposed
  // because reads are gated by count.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wa) mem[wptr] <= w_data;
  end

  if (MODE == fifo_pkg::FWFT) begin : g_fwft
    // Head word is presented directly; rd acknowledges it.
    assign r_data = mem[rptr];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] r_data_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)  r_data_q <= '0;
      else if (ra) r_data_q <= mem[rptr];
    end
    assign r_data = r_data_q;
  end

endmodule

// File: tb/tb_configurable_fifo.sv
module tb_configurable_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rd = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] w_data = '0;

  // Standard-mode instance with custom thresholds.
  logic [7:0] s_rdata;
  logic [3:0] s_count;
  logic       s_empty, s_full, s_ae, s_af, s_ovf, s_unf;
  // FWFT instance with default thresholds (AF=7, AE=1).
  logic [7:0] f_rdata;
  logic [3:0] f_count;
  logic       f_empty, f_full, f_ae, f_af, f_ovf, f_unf;

  configurable_fifo #(
    .ADDR_WIDTH(3), .DATA_WIDTH(8), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(2)
  ) u_std (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .w_data(w_data),
    .r_data(s_rdata), .empty(s_empty), .full(s_full),
    .almost_empty(s_ae), .almost_full(s_af), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf)
  );

  configurable_fifo #(
    .ADDR_WIDTH(3), .DATA_WIDTH(8), .FWFT(1)
  ) u_fwft (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .w_data(w_data),
    .r_data(f_rdata), .empty(f_empty), .full(f_full),
    .almost_empty(f_ae), .almost_full(f_af), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf)
  );

  // clock / reset
  always #5 clk = ~clk;

  wire [9:0] s_stat = {s_count, s_empty, s_full, s_ae, s_af, s_ovf, s_unf};
  wire [9:0] f_stat = {f_count, f_empty, f_full, f_ae, f_af, f_ovf, f_unf};

  // scoreboard / reference model
  logic [7:0] exp_q[$];
  logic       exp_ovf  = 1'b0;
  logic       exp_unf  = 1'b0;
  logic [7:0] exp_rstd = '0;
  int         n_cmp = 0;
  int         n_err = 0;

  function automatic logic [9:0] exp_stat(input int ae, input int af);
    int n;
    n = exp_q.size();
    return {4'(n), n == 0, n == 8, n <= ae, n >= af, exp_ovf, exp_unf};
  endfunction

  function automatic logic [7:0] exp_head();
    return exp_q[0];
  endfunction

  task automatic model_clear();
    exp_q.delete();
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
    exp_rstd = '0;
  endtask

  // driver: present one request cycle, advance the model at the edge,
  // return 1 ns after the edge with the inputs idle
  task automatic cycle(input logic r, input logic w, input logic [7:0] d);
    bit was_full, was_empty;
    rd = r; wr = w; w_data = d;
    @(posedge clk);
    was_full  = (exp_q.size() == 8);
    was_empty = (exp_q.size() == 0);
    exp_ovf = w && was_full && !r;
    exp_unf = r && was_empty;
    if (r && !was_empty) begin
      exp_rstd = exp_q.pop_front();
    end
    if (w && (!was_full || r)) exp_q.push_back(d);
    #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    #2;  // before any clock edge: clear must be asynchronous
    model_clear();
    n_cmp += 2;
    if (s_stat !== exp_stat(2, 6)) begin
      n_err++; $display("FAIL reset_async_std stat act=%b exp=%b", s_stat, exp_stat(2, 6));
    end
    if (s_rdata !== 8'h00) begin
      n_err++; $display("FAIL reset_async_rdata act=%h exp=00", s_rdata);
    end
    @(posedge clk); #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'($urandom_range(1, 255)));
    cycle(1'b1, 1'b0, 8'h00);  // loads a nonzero word into the std r_data register
    reset = 1'b0;
    #2;
    model_clear();
    n_cmp += 3;
    if (s_stat !== exp_stat(2, 6)) begin
      n_err++; $display("FAIL reset_mid_std stat act=%b exp=%b", s_stat, exp_stat(2, 6));
    end
    if (f_stat !== exp_stat(1, 7)) begin
      n_err++; $display("FAIL reset_mid_fwft stat act=%b exp=%b", f_stat, exp_stat(1, 7));
    end
    if (s_rdata !== exp_rstd) begin
      n_err++; $display("FAIL reset_mid_rdata act=%h exp=%h", s_rdata, exp_rstd);
    end
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic test_fill_drain();
    // 9 writes (last one overflows), then 9 reads (last one underflows)
    for (int i = 0; i < 18; i++) begin
      if (i < 9) cycle(1'b0, 1'b1, 8'(i + 1));
      else       cycle(1'b1, 1'b0, 8'h00);
      n_cmp += 3;
      if (s_stat !== exp_stat(2, 6)) begin
        n_err++; $display("FAIL fill_drain_std[%0d] stat act=%b exp=%b", i, s_stat, exp_stat(2, 6));
      end
      if (f_stat !== exp_stat(1, 7)) begin
        n_err++; $display("FAIL fill_drain_fwft[%0d] stat act=%b exp=%b", i, f_stat, exp_stat(1, 7));
      end
      if (s_rdata !== exp_rstd) begin
        n_err++; $display("FAIL fill_drain_rdata[%0d] act=%h exp=%h", i, s_rdata, exp_rstd);
      end
      if (exp_q.size() != 0) begin
        n_cmp++;
        if (f_rdata !== exp_head()) begin
          n_err++; $display("FAIL fill_drain_fwft_rdata[%0d] act=%h exp=%h", i, f_rdata, exp_head());
        end
      end
    end
  endtask

  task automatic test_fwft_single();
    cycle(1'b0, 1'b1, 8'hA5);
    cycle(1'b0, 1'b0, 8'h00);  // no rd: word must already be presented
    n_cmp += 2;
    if (f_rdata !== 8'hA5) begin
      n_err++; $display("FAIL fwft_present act=%h exp=a5", f_rdata);
    end
    if (f_stat !== exp_stat(1, 7)) begin
      n_err++; $display("FAIL fwft_present_stat act=%b exp=%b", f_stat, exp_stat(1, 7));
    end
    cycle(1'b1, 1'b0, 8'h00);
    n_cmp += 2;
    if (f_empty !== 1'b1) begin
      n_err++; $display("FAIL fwft_ack_empty act=%b exp=1", f_empty);
    end
    if (s_rdata !== exp_rstd) begin
      n_err++; $display("FAIL fwft_ack_std_rdata act=%h exp=%h", s_rdata, exp_rstd);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'($urandom_range(0, 255)));
    cycle(1'b1, 1'b1, 8'h55);  // full: both accepted
    for (int i = 0; i < 9; i++) begin
      n_cmp += 3;
      if (s_stat !== exp_stat(2, 6)) begin
        n_err++; $display("FAIL simul_full_std[%0d] stat act=%b exp=%b", i, s_stat, exp_stat(2, 6));
      end
      if (f_stat !== exp_stat(1, 7)) begin
        n_err++; $display("FAIL simul_full_fwft[%0d] stat act=%b exp=%b", i, f_stat, exp_stat(1, 7));
      end
      if (s_rdata !== exp_rstd) begin
        n_err++; $display("FAIL simul_full_rdata[%0d] act=%h exp=%h", i, s_rdata, exp_rstd);
      end
      if (i < 8) cycle(1'b1, 1'b0, 8'h00);
    end
    n_cmp++;
    if (s_rdata !== 8'h55) begin
      n_err++; $display("FAIL simul_full_last act=%h exp=55", s_rdata);
    end
    cycle(1'b1, 1'b1, 8'h33);  // empty: write taken, read rejected
    n_cmp += 3;
    if (s_stat !== exp_stat(2, 6)) begin
      n_err++; $display("FAIL simul_empty_std stat act=%b exp=%b", s_stat, exp_stat(2, 6));
    end
    if (f_stat !== exp_stat(1, 7)) begin
      n_err++; $display("FAIL simul_empty_fwft stat act=%b exp=%b", f_stat, exp_stat(1, 7));
    end
    if (f_rdata !== 8'h33) begin
      n_err++; $display("FAIL simul_empty_fwft_rdata act=%h exp=33", f_rdata);
    end
    cycle(1'b1, 1'b0, 8'h00);
    n_cmp++;
    if (s_rdata !== 8'h33) begin
      n_err++; $display("FAIL simul_empty_read act=%h exp=33", s_rdata);
    end
  endtask

  task automatic test_random();
    // alternate fill-biased and drain-biased phases to cross both
    // thresholds and wrap the pointers many times
    for (int i = 0; i < 400; i++) begin
      bit fill_phase;
      logic r, w;
      fill_phase = ((i / 25) % 2) == 0;
      r = $urandom_range(0, 99) < (fill_phase ? 30 : 70);
      w = $urandom_range(0, 99) < (fill_phase ? 70 : 30);
      cycle(r, w, 8'($urandom_range(0, 255)));
      n_cmp += 3;
      if (s_stat !== exp_stat(2, 6)) begin
        n_err++; $display("FAIL random_std[%0d] stat act=%b exp=%b", i, s_stat, exp_stat(2, 6));
      end
      if (f_stat !== exp_stat(1, 7)) begin
        n_err++; $display("FAIL random_fwft[%0d] stat act=%b exp=%b", i, f_stat, exp_stat(1, 7));
      end
      if (s_rdata !== exp_rstd) begin
        n_err++; $display("FAIL random_rdata[%0d] act=%h exp=%h", i, s_rdata, exp_rstd);
      end
      if (exp_q.size() != 0) begin
        n_cmp++;
        if (f_rdata !== exp_head()) begin
          n_err++; $display("FAIL random_fwft_rdata[%0d] act=%h exp=%h", i, f_rdata, exp_head());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_fwft_single();
    test_simultaneous();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
